// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: four CPOL/CPHA modes, parametrised width/bit order; `SPI_SLAVE_RX_FIFO_EN adds an rx FIFO with rx_ready/rx_overrun.
// Latency: rx word one clk after the synced last sample edge; backpressure: tx valid/ready, rx none (or FIFO + overrun drop).
module spi_slave_param #(
  parameter int                    DATA_WIDTH    = 8,
  parameter bit                    LSB_FIRST     = 1'b0,
  parameter int                    SYNC_STAGES   = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD  = '1,
  parameter int                    RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLAVE_RX_FIFO_EN
  input  logic                  rx_ready,
  output logic                  rx_overrun,
`endif
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int CW = $clog2(DATA_WIDTH);

  if (DATA_WIDTH < 2 || SYNC_STAGES < 2 || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_slave_param: illegal parameter value");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_prev;
  logic                   armed, cpol, cpha, tx_full;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  tx_sh, rx_sh, tx_buf, load_word, rx_next;
  logic                   in_frame, lead_e, trail_e, sample_e, shift_e;
  logic                   start, stop, word_done, load;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // cs chain resets low so a reset taken mid-frame cannot look like a fresh assertion
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q    <= '0;
      cs_q      <= '0;
      mosi_q    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign lead_e    = cpol ? (sclk_prev & ~sclk_s) : (~sclk_prev & sclk_s);
  assign trail_e   = cpol ? (~sclk_prev & sclk_s) : (sclk_prev & ~sclk_s);
  assign in_frame  = (state == ACTIVE) && !cs_s;
  assign sample_e  = in_frame && (cpha ? trail_e : lead_e);
  assign shift_e   = in_frame && (cpha ? lead_e : trail_e);
  assign word_done = sample_e && (bit_cnt == CW'(DATA_WIDTH - 1));
  assign start     = (state == IDLE) && armed && !cs_s;
  assign stop      = (state == ACTIVE) && cs_s;
  assign load      = start || word_done;
  assign load_word = tx_full ? tx_buf : TX_IDLE_WORD;
  assign rx_next   = LSB_FIRST ? {mosi_s, rx_sh[DATA_WIDTH-1:1]}
                               : {rx_sh[DATA_WIDTH-2:0], mosi_s};
  assign tx_ready  = !tx_full;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  if (stop)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed       <= 1'b0;
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load && !tx_full;
      if (cs_s)       armed <= 1'b1;
      else if (start) armed <= 1'b0;

      // load sees the old buffer, so an accept in the same cycle is kept for the next word
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (load) begin
        tx_full <= 1'b0;
      end

      if (start) begin
        cpol    <= mode[1];
        cpha    <= mode[0];
        bit_cnt <= '0;
        rx_sh   <= '0;
        busy    <= 1'b1;
        miso_oe <= 1'b1;
        if (mode[0]) begin
          tx_sh <= load_word;
        end else begin
          miso  <= first_bit(load_word);
          tx_sh <= advance(load_word);
        end
      end else if (stop) begin
        busy    <= 1'b0;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (sample_e) begin
          rx_sh   <= rx_next;
          bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
        // the reloaded word is presented by the following shift edge
        if (word_done) begin
          tx_sh <= load_word;
        end else if (shift_e) begin
          miso  <= first_bit(tx_sh);
          tx_sh <= advance(tx_sh);
        end
      end
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0]           wp, rp;
  logic                  empty, full, pop, push;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop      = !empty && rx_ready;
  assign push     = word_done && (!full || pop);
  assign rx_valid = !empty;
  assign rx_data  = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      rx_overrun <= word_done && !push;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) rx_data <= rx_next;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: 8-bit MSB-first and 16-bit LSB-first instances on a shared bus.
module tb_spi_slave_param;
  localparam int H = 8;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        sclk = 1'b0, mosi = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
  logic        miso0, miso_oe0, tx_ready0, rx_valid0, busy0, tx_underrun0;
  logic        miso1, miso_oe1, tx_ready1, rx_valid1, busy1, tx_underrun1;
  logic [7:0]  tx_data0 = '0, rx_data0;
  logic [15:0] tx_data1 = '0, rx_data1;
  logic        tx_valid0 = 1'b0, tx_valid1 = 1'b0;
  logic        rx_rdy0 = 1'b1, rx_rdy1 = 1'b1;
`ifdef SPI_SLAVE_RX_FIFO_EN
  logic        rx_ovr0, rx_ovr1;
`endif

  int checks = 0, errors = 0;
  int und0 = 0, ovr0 = 0, bad_chg = 0, und_snap = 0;
  logic bad_win = 1'b0, miso0_q = 1'b0, miso1_q = 1'b0;
  logic [7:0]  exp0[$];
  logic [15:0] exp1[$];

  always #5 clk = ~clk;

  spi_slave_param u0 (
    .clk(clk), .reset(reset), .mode(mode), .sclk(sclk), .cs_n(cs0_n), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
`ifdef SPI_SLAVE_RX_FIFO_EN
    .rx_ready(rx_rdy0), .rx_overrun(rx_ovr0),
`endif
    .busy(busy0), .tx_underrun(tx_underrun0));

  spi_slave_param #(.DATA_WIDTH(16), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .mode(mode), .sclk(sclk), .cs_n(cs1_n), .mosi(mosi),
    .miso(miso1), .miso_oe(miso_oe1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
`ifdef SPI_SLAVE_RX_FIFO_EN
    .rx_ready(rx_rdy1), .rx_overrun(rx_ovr1),
`endif
    .busy(busy1), .tx_underrun(tx_underrun1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a DUT hands over a received word
  initial begin
    logic [7:0]  e0;
    logic [15:0] e1;
    forever begin
      @(negedge clk);
      if (tx_underrun0) und0++;
`ifdef SPI_SLAVE_RX_FIFO_EN
      if (rx_ovr0) ovr0++;
`endif
      if (bad_win && (miso0 !== miso0_q || miso1 !== miso1_q)) bad_chg++;
      miso0_q = miso0;
      miso1_q = miso1;
      if (!reset && rx_valid0 && rx_rdy0) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx0_extra: got %h expected no word", rx_data0);
        end else begin
          e0 = exp0.pop_front();
          chk("rx0", {24'h0, rx_data0}, {24'h0, e0});
        end
      end
      if (!reset && rx_valid1 && rx_rdy1) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx1_extra: got %h expected no word", rx_data1);
        end else begin
          e1 = exp1.pop_front();
          chk("rx1", {16'h0, rx_data1}, {16'h0, e1});
        end
      end
    end
  end

  task automatic tx_push(input int dut, input logic [15:0] d);
    int n = 0;
    while (((dut == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL tx_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    if (dut == 0) begin tx_data0 = d[7:0]; tx_valid0 = 1'b1; end
    else          begin tx_data1 = d;      tx_valid1 = 1'b1; end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    chk("tx_ready_low", {31'h0, (dut == 0) ? tx_ready0 : tx_ready1}, 32'h0);
  endtask

  // SPI master: word k occupies stream[k*w +: w]; got is packed the same way
  task automatic spi_frame(input int dut, input logic [1:0] m, input int w, input bit lsb,
                           input int nbits, input logic [79:0] stream, output logic [79:0] got);
    int k, j, idx;
    got  = '0;
    mode = m;
    sclk = m[1];
    repeat (2*H) @(negedge clk);
    if (dut == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_on", {31'h0, (dut == 0) ? (busy0 & miso_oe0) : (busy1 & miso_oe1)}, 32'h1);
    for (int b = 0; b < nbits; b++) begin
      k   = b / w;
      j   = b % w;
      idx = k*w + (lsb ? j : w-1-j);
      if (b == w+1) und_snap = und0;
      if (!m[0]) begin
        mosi = stream[idx];
        repeat (H) @(negedge clk);
        sclk = ~m[1]; got[idx] = (dut == 0) ? miso0 : miso1; bad_win = 1'b1;
        repeat (H) @(negedge clk);
        sclk = m[1]; bad_win = 1'b0;
      end else begin
        sclk = ~m[1]; mosi = stream[idx]; bad_win = 1'b0;
        repeat (H) @(negedge clk);
        sclk = m[1]; got[idx] = (dut == 0) ? miso0 : miso1; bad_win = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    bad_win = 1'b0;
    repeat (H) @(negedge clk);
    cs0_n = 1'b1;
    cs1_n = 1'b1;
    repeat (2*H) @(negedge clk);
    chk("busy_off", {30'h0, busy0 | busy1, miso_oe0 | miso_oe1}, 32'h0);
  endtask

  initial begin
    logic [79:0] got;
    int b0, u0c;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    chk("rst_tx_ready", {31'h0, tx_ready0}, 32'h1);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_miso", {30'h0, miso0, miso_oe0}, 32'h0);
    chk("rst_rx", {23'h0, rx_valid0, rx_data0}, 32'h0);
    chk("rst_underrun", {31'h0, tx_underrun0}, 32'h0);
    repeat (6) @(negedge clk);

    // same word pair in every mode
    for (int m = 0; m < 4; m++) begin
      tx_push(0, 16'h00D4);
      exp0.push_back(8'hAA);
      b0 = bad_chg;
      spi_frame(0, 2'(m), 8, 1'b0, 8, 80'hAA, got);
      chk($sformatf("m%0d_master_rx", m), {24'h0, got[7:0]}, 32'hD4);
      chk($sformatf("m%0d_tx_ready", m), {31'h0, tx_ready0}, 32'h1);
      chk($sformatf("m%0d_miso_edge", m), bad_chg - b0, 32'h0);
    end

    // two words, one queued: second word falls back to the idle pattern
    tx_push(0, 16'h003C);
    exp0.push_back(8'h81);
    exp0.push_back(8'h7E);
    u0c = und0;
    spi_frame(0, 2'b00, 8, 1'b0, 16, 80'h7E81, got);
    chk("bb_word0", {24'h0, got[7:0]}, 32'h3C);
    chk("bb_word1", {24'h0, got[15:8]}, 32'hFF);
    chk("bb_underrun", und_snap - u0c, 32'h1);

    // reset mid-frame: remainder ignored, no word
    fork
      spi_frame(0, 2'b00, 8, 1'b0, 8, 80'hAB, got);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join

    // abort after 5 bits; buffered word survives for the next frame
    tx_push(0, 16'h0011);
    fork
      spi_frame(0, 2'b00, 8, 1'b0, 5, 80'h1F, got);
      begin
        repeat (2*H + 10) @(negedge clk);
        tx_push(0, 16'h0069);
      end
    join
    exp0.push_back(8'h55);
    spi_frame(0, 2'b00, 8, 1'b0, 8, 80'h55, got);
    chk("abort_next_tx", {24'h0, got[7:0]}, 32'h69);

    // 16-bit LSB-first instance
    tx_push(1, 16'hBEEF);
    exp1.push_back(16'h1234);
    spi_frame(1, 2'b00, 16, 1'b1, 16, 80'h1234, got);
    chk("w16_master_rx", {16'h0, got[15:0]}, 32'hBEEF);

`ifdef SPI_SLAVE_RX_FIFO_EN
    rx_rdy0 = 1'b0;
    u0c = ovr0;
    spi_frame(0, 2'b00, 8, 1'b0, 40, 80'h0504030201, got);
    chk("fifo_valid", {31'h0, rx_valid0}, 32'h1);
    chk("fifo_overrun", ovr0 - u0c, 32'h1);
    for (int i = 1; i <= 4; i++) exp0.push_back(8'(i));
    rx_rdy0 = 1'b1;
`endif

    for (int n = 0; n < 200 && (exp0.size() != 0 || exp1.size() != 0); n++) @(negedge clk);
    chk("exp0_drained", exp0.size(), 32'h0);
    chk("exp1_drained", exp1.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave; successor to the fixed 8-bit, single-mode slave. Runs on the system clock and oversamples the external SPI pins. Supports all four CPOL/CPHA modes, a configurable word width and bit order, and back-to-back words within one chip-select frame. Sits between an off-chip SPI master and the on-chip register/datapath logic, using valid/ready handshakes on the parallel side.

Parameters:
DATA_WIDTH, 8, bits per SPI word (min 2)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB first
SYNC_STAGES, 2, flops in each pin synchroniser (min 2)
TX_IDLE_WORD, all ones, word sent when no tx data is queued
RX_FIFO_DEPTH, 4, rx FIFO entries, power of 2; used only with SPI_SLAVE_RX_FIFO_EN

Ports:
clk  in  1  system clock; must be at least 4x the sclk frequency
reset  in  1  synchronous, active-high reset
mode  in  2  {CPOL,CPHA}; latched on CS assertion
sclk  in  1  SPI serial clock, asynchronous
cs_n  in  1  chip select, active low, asynchronous
mosi  in  1  master-out serial data, asynchronous
miso  out  1  slave-out serial data
miso_oe  out  1  miso output enable for the pad tristate
tx_data  in  DATA_WIDTH  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx holding buffer empty
rx_data  out  DATA_WIDTH  last received word
rx_valid  out  1  received word strobe
busy  out  1  frame in progress
tx_underrun  out  1  1-cycle pulse: word loaded while tx buffer empty

Behaviour:
- Synchronisers: sclk, cs_n and mosi each pass through SYNC_STAGES flops before use. Edges are detected on the synchronised sclk against its previous value.
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0. State is IDLE and the tx buffer is empty.
- Tx handshake: the tx buffer holds one word. A word is accepted when tx_valid && tx_ready. tx_ready goes low the following cycle and returns high the cycle after the buffer is loaded into the shifter.
- State IDLE -> ACTIVE on synced cs_n high-to-low, but only if not blocked (see reset). Actions on the transition:
  - latch mode;
  - clear bit_cnt;
  - load the tx shifter from the buffer, or with TX_IDLE_WORD if the buffer is empty (tx_underrun pulses);
  - set busy=1 and miso_oe=1.
- In ACTIVE, leading edge = sclk leaving the CPOL level; trailing edge = the opposite transition.
  - CPHA=0: first bit is on miso at CS assertion; sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges (first bit appears on the first leading edge); sample on trailing edges.
- Word completion: on the DATA_WIDTH-th sample, rx_data is updated and rx_valid pulses high for exactly one clk, one clk after the synced edge is detected. bit_cnt wraps to 0 and the tx shifter reloads (buffer or TX_IDLE_WORD) in the same cycle, so back-to-back words need no gap.
- Bit order: LSB_FIRST selects the shift and assembly direction for both rx and tx.
- ACTIVE -> IDLE on synced cs_n rising, with any bit count:
  - busy=0, miso_oe=0, miso=0;
  - a partial rx word is discarded with no rx_valid;
  - a tx word already in the shifter is lost; the buffer is untouched.
- mode changes while ACTIVE are ignored until the next frame.
- Reset asserted mid-frame: state returns to IDLE and the remainder of the current frame is ignored. The block re-arms only after synced cs_n has been seen high.
- Simultaneous tx accept and shifter load in the same cycle: the load takes the previously buffered word, or TX_IDLE_WORD if the buffer was empty; the newly accepted word is stored for the next word.

Optional Feature:
Macro SPI_SLAVE_RX_FIFO_EN.
- Without it: rx_data and rx_valid behave as above, with no backpressure.
- With it: an input rx_ready and an output rx_overrun are added.
  - A RX_FIFO_DEPTH-entry FIFO sits on the rx side; rx_data shows the FIFO head.
  - rx_valid is a level meaning "FIFO not empty"; a pop occurs on rx_valid && rx_ready.
  - A word completing while the FIFO is full is dropped and rx_overrun pulses for 1 cycle.
  - A push and a pop in the same cycle while full is accepted.

Test Plan:
- Mode 0, tx_data=8'hD4 queued, master sends 8'hAA -> rx_data=8'hAA with one rx_valid pulse; master receives 8'hD4; tx_ready returns to 1.
- Modes 1, 2 and 3, each with the same stimulus -> identical rx/tx words; miso changes only on that mode's shift edge.
- One frame with 2 words, only 8'h3C queued -> master receives 8'h3C then 8'hFF; tx_underrun pulses once at the second load; rx_valid pulses twice.
- cs_n deasserted after 5 bits, then a full frame sending 8'h55 -> no rx_valid for the aborted word; next rx_data=8'h55.
- LSB_FIRST=1, DATA_WIDTH=16, master sends 16'h1234 LSB first -> rx_data=16'h1234.
- With SPI_SLAVE_RX_FIFO_EN, rx_ready=0, 5 words sent -> FIFO holds the first 4; rx_overrun pulses on word 5; draining yields words 1-4 in order.
